canon_sequencer: RTL

- Parametrised successor to the fixed three-violin/one-cello note sequencer.
- Drives N_VOICES canon voices over a shared, time-multiplexed divider bus to the existing sample/PWM chain.
- Each voice fetches note codes from an external synchronous note ROM. Voice entries are staggered, loop bounds are runtime-programmable, and start/pause control is included.

---
 rtl/canon_pkg.sv | 34 +++
 rtl/canon_voice.sv | 62 ++++++
 rtl/canon_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/canon_pkg.sv
// canon_pkg: shared pitch table and duration helpers for the canon sequencer.
// Divider values assume the 36 MHz project clock.
package canon_pkg;

  localparam int N_PITCH = 18;

  localparam logic [15:0] PITCH_TABLE [N_PITCH] = '{
    16'd0,   16'd568, 16'd506, 16'd477, 16'd425, 16'd379,
    16'd357, 16'd318, 16'd283, 16'd252, 16'd238, 16'd212,
    16'd189, 16'd178, 16'd158, 16'd141, 16'd125, 16'd118
  };

  localparam logic [1:0] DUR_LONG  = 2'b10;
  localparam logic [2:0] MASK_LONG = 3'b111;

  function automatic logic [2:0] dur_mask_from_code(
    input logic [1:0] code
  );
    return (code == DUR_LONG) ? MASK_LONG : {1'b0, code};
  endfunction

  // Codes past the end of the table fall through to silence.
  function automatic logic [15:0] pitch_div(
    input logic [4:0] pitch
  );
    logic [15:0] div;
    div = '0;
    for (int i = 0; i < N_PITCH; i++) begin
      if (pitch == 5'(i)) div = PITCH_TABLE[i];
    end
    return div;
  endfunction

endpackage

// File: rtl/canon_voice.sv
// canon_voice: one canon voice -- note index, active flag and the
// duration mask that gates advancing on beat ticks.
module canon_voice
  import canon_pkg::*;
#(
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  input  logic             first_i,
  input  logic             enter_i,
  input  logic             tick_i,
  input  logic [2:0]       sub_beat_i,
  input  logic [IDX_W-1:0] loop_start_i,
  input  logic [IDX_W-1:0] loop_end_i,
  input  logic             mask_we_i,
  input  logic [1:0]       dur_code_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             active_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             active_q, active_d;
  logic [2:0]       mask_q, mask_d;
  logic             hold;

  assign hold = |(sub_beat_i & mask_q);

  always_comb begin
    idx_d    = idx_q;
    active_d = active_q;
    mask_d   = mask_q;
    if (mask_we_i) mask_d = dur_mask_from_code(dur_code_i);
    if (restart_i) begin
      idx_d    = loop_start_i;
      active_d = first_i;
    end else if (enter_i) begin
      idx_d    = loop_start_i;
      active_d = 1'b1;
    end else if (tick_i && active_q && !hold) begin
      idx_d = (idx_q == loop_end_i) ? loop_start_i
                                    : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      active_q <= 1'b0;
      mask_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      active_q <= active_d;
      mask_q   <= mask_d;
    end
  end

  assign idx_o    = idx_q;
  assign active_o = active_q;

endmodule

// File: rtl/canon_sequencer.sv
// canon_sequencer: N staggered canon voices sharing one note ROM and a
// time-multiplexed divider bus (slot -> ROM -> divider, 2-cycle latency).
module canon_sequencer
  import canon_pkg::*;
#(
  parameter int N_VOICES    = 4,
  parameter int IDX_W       = 9,
  parameter int DIV_W       = 10,
  parameter int BEAT_W      = 22,
  parameter int ENTRY_BEATS = 8,
  localparam int SEL_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic [IDX_W-1:0] loop_start,
  input  logic [IDX_W-1:0] loop_end,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [6:0]       rom_data,
  output logic [DIV_W-1:0] divider,
  output logic [SEL_W-1:0] voice_sel,
  output logic             divider_valid,
  output logic             tick,
  output logic             playing
);

  localparam int ENT_MAX = (N_VOICES - 1) * ENTRY_BEATS;
  localparam int ENT_W   = $clog2(ENT_MAX + 2);

  logic             playing_q;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [2:0]       sub_q, sub_d;
  logic [ENT_W-1:0] entry_q, entry_d, entry_nx;
  logic             run, tick_w, entry_inc;

  logic [IDX_W-1:0] rom_addr_q;
  logic [SEL_W-1:0] slot_a_q, slot_r_q, voice_sel_q;
  logic             vld_a_q, vld_r_q, divider_valid_q;
  logic [DIV_W-1:0] divider_q;

  logic [IDX_W-1:0] idx_w [N_VOICES];
  logic             act_w [N_VOICES];
  logic [IDX_W-1:0] idx_sel;
  logic             act_r;

  assign run       = playing_q && !pause && !start;
  assign tick_w    = run && (beat_q == '1);
  assign entry_inc = tick_w && (entry_q != ENT_W'(ENT_MAX));
  assign entry_nx  = entry_q + ENT_W'(1);

  always_comb begin
    slot_d  = slot_q;
    beat_d  = beat_q;
    sub_d   = sub_q;
    entry_d = entry_q;
    if (start) begin
      slot_d  = '0;
      beat_d  = '0;
      sub_d   = '0;
      entry_d = '0;
    end else if (playing_q) begin
      slot_d = (slot_q == SEL_W'(N_VOICES - 1)) ? '0
                                                : slot_q + SEL_W'(1);
      if (run)       beat_d  = beat_q + BEAT_W'(1);
      if (tick_w)    sub_d   = sub_q + 3'd1;
      if (entry_inc) entry_d = entry_nx;
    end
  end

  always_comb begin
    idx_sel = '0;
    act_r   = 1'b0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (slot_q == SEL_W'(v))   idx_sel = idx_w[v];
      if (slot_r_q == SEL_W'(v)) act_r   = act_w[v];
    end
  end

  for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
    logic enter;
    if (v == 0) begin : g_lead
      assign enter = 1'b0;
    end else begin : g_follow
      assign enter = entry_inc &&
                     (entry_nx == ENT_W'(v * ENTRY_BEATS));
    end
    canon_voice #(.IDX_W(IDX_W)) u_voice (
      .clk          (clk),
      .rst          (rst),
      .restart_i    (start),
      .first_i      (v == 0),
      .enter_i      (enter),
      .tick_i       (tick_w),
      .sub_beat_i   (sub_q),
      .loop_start_i (loop_start),
      .loop_end_i   (loop_end),
      .mask_we_i    (vld_r_q && (slot_r_q == SEL_W'(v))),
      .dur_code_i   (rom_data[6:5]),
      .idx_o        (idx_w[v]),
      .active_o     (act_w[v])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      playing_q <= 1'b0;
      slot_q    <= '0;
      beat_q    <= '0;
      sub_q     <= '0;
      entry_q   <= '0;
    end else begin
      playing_q <= playing_q || start;
      slot_q    <= slot_d;
      beat_q    <= beat_d;
      sub_q     <= sub_d;
      entry_q   <= entry_d;
    end
  end

  // The pipeline keeps cycling through pause; only the divider is muted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q      <= '0;
      slot_a_q        <= '0;
      vld_a_q         <= 1'b0;
      slot_r_q        <= '0;
      vld_r_q         <= 1'b0;
      divider_q       <= '0;
      voice_sel_q     <= '0;
      divider_valid_q <= 1'b0;
    end else begin
      if (playing_q) begin
        rom_addr_q <= idx_sel;
        slot_a_q   <= slot_q;
      end
      vld_a_q         <= playing_q;
      slot_r_q        <= slot_a_q;
      vld_r_q         <= vld_a_q;
      divider_q       <= (vld_r_q && act_r && !pause)
                         ? DIV_W'(pitch_div(rom_data[4:0])) : '0;
      voice_sel_q     <= vld_r_q ? slot_r_q : '0;
      divider_valid_q <= vld_r_q;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign divider       = divider_q;
  assign voice_sel     = voice_sel_q;
  assign divider_valid = divider_valid_q;
  assign tick          = tick_w;
  assign playing       = playing_q;

endmodule
